// File: rtl/can_bit_destuffer.sv
`default_nettype none
// ============================================================================
// Module   : can_bit_destuffer
// Brief    : CAN receive-path bit de-stuffer (dynamic and fixed/FD-CRC modes)
// Revision : 1.0 - initial release
// ============================================================================
module can_bit_destuffer #(
    parameter int RUN_LEN   = 5,
    parameter int FIXED_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bit_in,
    input  logic             i_bit_valid,
    input  logic             i_frame_start,
    input  logic             i_stuff_en,
    input  logic             i_fixed_mode,
    output logic             o_bit_out,
    output logic             o_bit_out_valid,
    output logic             o_stuff_drop,
    output logic             o_error_stuff,
    output logic [CNT_W-1:0] o_stuff_count
);

    localparam logic [3:0] c_RUN_LEN   = 4'(RUN_LEN);
    localparam logic [3:0] c_FIXED_LEN = 4'(FIXED_LEN);

    // ST_FIRST: init=0, ST_DATA: init=1/skip=0, ST_SKIP: skip=1
    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_DATA  = 2'd1,
        ST_SKIP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_cur;
    state_t           w_state_nxt;
    logic             r_last_bit;
    logic [3:0]       r_run;
    logic [3:0]       w_run_cur;
    logic [3:0]       w_run_inc;
    logic [3:0]       w_run_nxt;
    logic [3:0]       r_fcnt;
    logic [3:0]       w_fcnt_cur;
    logic [3:0]       w_fcnt_nxt;
    logic             r_fixed_d;
    logic             w_fixed_d_cur;
    logic             w_fixed_d_nxt;
    logic [CNT_W-1:0] r_stuff_count;
    logic [CNT_W-1:0] w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_bit_out;
    logic             w_bit_out_nxt;
    logic             r_bit_out_valid;
    logic             r_stuff_drop;
    logic             r_error_stuff;
    logic             w_fwd;
    logic             w_drop;
    logic             w_err;

    // frame_start clears per-frame state before the same-cycle bit is processed
    always_comb begin
        w_state_cur   = i_frame_start ? ST_FIRST : r_state;
        w_run_cur     = i_frame_start ? 4'd0     : r_run;
        w_fcnt_cur    = i_frame_start ? 4'd0     : r_fcnt;
        w_fixed_d_cur = i_frame_start ? 1'b0     : r_fixed_d;
        w_cnt_cur     = i_frame_start ? '0       : r_stuff_count;
        w_run_inc     = (i_bit_in == r_last_bit) ? (w_run_cur + 4'd1) : 4'd1;
    end

    always_comb begin
        w_state_nxt   = w_state_cur;
        w_run_nxt     = w_run_cur;
        w_fcnt_nxt    = w_fcnt_cur;
        w_fixed_d_nxt = w_fixed_d_cur;
        w_cnt_nxt     = w_cnt_cur;
        w_fwd         = 1'b0;
        w_drop        = 1'b0;
        w_err         = 1'b0;

        if (i_bit_valid) begin
            w_fixed_d_nxt = i_stuff_en & i_fixed_mode;

            if (!i_stuff_en) begin
                w_fwd       = 1'b1;
                w_run_nxt   = 4'd1;
                w_state_nxt = ST_DATA;
                w_fcnt_nxt  = 4'd0;
            end else if (i_fixed_mode) begin
                w_run_nxt = 4'd0;
                if (w_state_cur == ST_SKIP) begin
                    w_state_nxt = ST_DATA;
                end
                // Entry into fixed mode always starts with a stuff bit
                if (!w_fixed_d_cur || (w_fcnt_cur == c_FIXED_LEN)) begin
                    w_fcnt_nxt = 4'd0;
                    if (i_bit_in != r_last_bit) begin
                        w_drop = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else begin
                    w_fwd      = 1'b1;
                    w_fcnt_nxt = w_fcnt_cur + 4'd1;
                end
            end else begin
                w_fcnt_nxt = 4'd0;
                case (w_state_cur)
                    ST_SKIP: begin
                        if (i_bit_in != r_last_bit) begin
                            w_drop      = 1'b1;
                            w_cnt_nxt   = w_cnt_cur + CNT_W'(1);
                            w_run_nxt   = 4'd1;
                            w_state_nxt = ST_DATA;
                        end else begin
                            w_err       = 1'b1;
                            w_run_nxt   = 4'd0;
                            w_state_nxt = ST_FIRST;
                        end
                    end
                    ST_DATA: begin
                        w_fwd       = 1'b1;
                        w_run_nxt   = w_run_inc;
                        w_state_nxt = (w_run_inc == c_RUN_LEN) ? ST_SKIP : ST_DATA;
                    end
                    default: begin
                        w_fwd       = 1'b1;
                        w_run_nxt   = 4'd1;
                        w_state_nxt = ST_DATA;
                    end
                endcase
            end
        end

        w_bit_out_nxt = w_fwd ? i_bit_in : r_bit_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_FIRST;
            r_last_bit      <= 1'b1;
            r_run           <= 4'd0;
            r_fcnt          <= 4'd0;
            r_fixed_d       <= 1'b0;
            r_stuff_count   <= '0;
            r_bit_out       <= 1'b0;
            r_bit_out_valid <= 1'b0;
            r_stuff_drop    <= 1'b0;
            r_error_stuff   <= 1'b0;
        end else begin
            if (i_bit_valid) begin
                r_last_bit <= i_bit_in;
            end
            r_state         <= w_state_nxt;
            r_run           <= w_run_nxt;
            r_fcnt          <= w_fcnt_nxt;
            r_fixed_d       <= w_fixed_d_nxt;
            r_stuff_count   <= w_cnt_nxt;
            r_bit_out       <= w_bit_out_nxt;
            r_bit_out_valid <= w_fwd;
            r_stuff_drop    <= w_drop;
            r_error_stuff   <= w_err;
        end
    end

    assign o_bit_out       = r_bit_out;
    assign o_bit_out_valid = r_bit_out_valid;
    assign o_stuff_drop    = r_stuff_drop;
    assign o_error_stuff   = r_error_stuff;
    assign o_stuff_count   = r_stuff_count;

endmodule
`default_nettype wire

// File: tb/tb_can_bit_destuffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_bit_destuffer
// Brief    : directed + randomized self-checking bench for can_bit_destuffer
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_bit_destuffer;

    localparam int RUN_LEN   = 5;
    localparam int FIXED_LEN = 4;
    localparam int CNT_W     = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_bit_in = 1'b0;
    logic             i_bit_valid = 1'b0;
    logic             i_frame_start = 1'b0;
    logic             i_stuff_en = 1'b1;
    logic             i_fixed_mode = 1'b0;
    logic             o_bit_out;
    logic             o_bit_out_valid;
    logic             o_stuff_drop;
    logic             o_error_stuff;
    logic [CNT_W-1:0] o_stuff_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a run is the list of identical bits seen so far;
    // a stuff bit is due once that list reaches RUN_LEN entries.
    bit          run_q[$];
    bit          m_last = 1'b1;
    bit          m_need_first = 1'b1;
    bit          m_in_fixed = 1'b0;
    int          m_fixed_cnt = 0;
    int unsigned m_count = 0;
    bit          m_bit_out = 1'b0;
    bit          e_valid, e_drop, e_err;

    can_bit_destuffer #(
        .RUN_LEN  (RUN_LEN),
        .FIXED_LEN(FIXED_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_bit_in       (i_bit_in),
        .i_bit_valid    (i_bit_valid),
        .i_frame_start  (i_frame_start),
        .i_stuff_en     (i_stuff_en),
        .i_fixed_mode   (i_fixed_mode),
        .o_bit_out      (o_bit_out),
        .o_bit_out_valid(o_bit_out_valid),
        .o_stuff_drop   (o_stuff_drop),
        .o_error_stuff  (o_error_stuff),
        .o_stuff_count  (o_stuff_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run_q.delete();
        m_last       = 1'b1;
        m_need_first = 1'b1;
        m_in_fixed   = 1'b0;
        m_fixed_cnt  = 0;
        m_count      = 0;
        m_bit_out    = 1'b0;
    endtask

    task automatic model(input bit b, input bit v, input bit fs, input bit en, input bit fm);
        e_valid = 1'b0;
        e_drop  = 1'b0;
        e_err   = 1'b0;
        if (fs) begin
            m_need_first = 1'b1;
            run_q.delete();
            m_fixed_cnt  = 0;
            m_in_fixed   = 1'b0;
            m_count      = 0;
        end
        if (v) begin
            if (!en) begin
                e_valid      = 1'b1;
                m_need_first = 1'b0;
                run_q        = '{b};
                m_in_fixed   = 1'b0;
            end else if (fm) begin
                run_q.delete();
                if (!m_in_fixed || m_fixed_cnt == FIXED_LEN) begin
                    m_fixed_cnt = 0;
                    if (b != m_last) e_drop = 1'b1;
                    else             e_err  = 1'b1;
                end else begin
                    e_valid = 1'b1;
                    m_fixed_cnt++;
                end
                m_in_fixed = 1'b1;
            end else begin
                m_in_fixed = 1'b0;
                if (m_need_first) begin
                    e_valid      = 1'b1;
                    m_need_first = 1'b0;
                    run_q        = '{b};
                end else if (run_q.size() == RUN_LEN) begin
                    if (b != m_last) begin
                        e_drop = 1'b1;
                        m_count++;
                        run_q = '{b};
                    end else begin
                        e_err        = 1'b1;
                        m_need_first = 1'b1;
                        run_q.delete();
                    end
                end else begin
                    e_valid = 1'b1;
                    if (run_q.size() != 0 && b == run_q[$]) run_q.push_back(b);
                    else                                    run_q = '{b};
                end
            end
            if (e_valid) m_bit_out = b;
            m_last = b;
        end
    endtask

    task automatic step(input bit b, input bit v, input bit fs, input bit en, input bit fm);
        logic [CNT_W-1:0] e_cnt;
        @(negedge clk);
        i_bit_in      = b;
        i_bit_valid   = v;
        i_frame_start = fs;
        i_stuff_en    = en;
        i_fixed_mode  = fm;
        model(b, v, fs, en, fm);
        e_cnt = CNT_W'(m_count);
        @(posedge clk);
        #1;
        chk("step", 32'({o_bit_out_valid, o_stuff_drop, o_error_stuff, o_bit_out, o_stuff_count}),
                    32'({e_valid, e_drop, e_err, m_bit_out, e_cnt}));
        i_bit_valid   = 1'b0;
        i_frame_start = 1'b0;
    endtask

    initial begin
        bit cur;
        bit r_en;
        bit r_fm;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 32'({o_bit_out_valid, o_stuff_drop, o_error_stuff, o_bit_out, o_stuff_count}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // dynamic run: 0 x5, stuff 1, data 0
        step(0, 1, 1, 1, 0);
        repeat (4) step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        chk("dyn_count", 32'(o_stuff_count), 32'd1);

        // violation then recovery as FIRST
        step(1, 1, 1, 1, 0);
        repeat (4) step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        chk("viol_err", 32'({o_error_stuff, o_bit_out_valid}), 32'b10);
        repeat (5) step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        chk("recover_drop", 32'(o_stuff_drop), 32'd1);

        // nine correctly stuffed runs wrap a 3-bit counter to 1
        cur = 1'b0;
        step(cur, 1, 1, 1, 0);
        repeat (4) step(cur, 1, 0, 1, 0);
        for (int r = 0; r < 9; r++) begin
            cur = ~cur;
            step(cur, 1, 0, 1, 0);
            if (r != 8) repeat (4) step(cur, 1, 0, 1, 0);
        end
        chk("wrap_count", 32'(o_stuff_count), 32'd1);
        step(0, 0, 1, 1, 0);
        chk("fs_clear", 32'(o_stuff_count), 32'd0);

        // fixed mode: last_bit=0, then 1,a,b,c,d,~d and a wrong-polarity stuff bit
        step(0, 1, 1, 1, 0);
        step(1, 1, 0, 1, 1);
        chk("fixed_entry_drop", 32'(o_stuff_drop), 32'd1);
        step(1, 1, 0, 1, 1);
        step(0, 1, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        step(0, 1, 0, 1, 1);
        chk("fixed_stuff_drop", 32'(o_stuff_drop), 32'd1);
        step(0, 1, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        step(0, 1, 0, 1, 1);
        step(0, 1, 0, 1, 1);
        chk("fixed_bad_err", 32'(o_error_stuff), 32'd1);
        chk("fixed_count", 32'(o_stuff_count), 32'd0);

        // pass-through then re-enable
        repeat (8) step(1, 1, 0, 0, 0);
        repeat (5) step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        chk("reenable_drop", 32'(o_stuff_drop), 32'd1);

        // frame_start with valid while a stuff bit is pending
        step(1, 1, 1, 1, 0);
        repeat (4) step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        chk("fs_in_skip", 32'({o_bit_out_valid, o_error_stuff}), 32'b10);

        // async reset mid-run with a bit in flight
        step(0, 1, 0, 1, 0);
        repeat (4) step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        @(negedge clk);
        i_bit_in    = 1'b1;
        i_bit_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 32'({o_bit_out_valid, o_stuff_drop, o_error_stuff, o_bit_out, o_stuff_count}), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold", 32'({o_bit_out_valid, o_stuff_drop, o_error_stuff, o_bit_out, o_stuff_count}), 32'd0);
        @(negedge clk);
        i_bit_valid = 1'b0;
        rst         = 1'b0;
        model_reset();

        // randomized traffic, biased towards long runs
        cur  = 1'b0;
        r_en = 1'b1;
        r_fm = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) r_en = ~r_en;
            if ($urandom_range(0, 29) == 0) r_fm = ~r_fm;
            if ($urandom_range(0, 4) == 0) cur = ~cur;
            step(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
                 r_en, r_en & r_fm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
